disp_share_arbiter: RTL and testbench



---
 rtl/disp_pkg.sv | 16 +
 rtl/rr_pick.sv | 31 +++
 rtl/disp_share_arbiter.sv | 110 +++++++++++
 tb/tb_disp_share_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display-sharing arbiter.
// The package itself has no build options; disp_share_arbiter honours DISP_BLANK_IDLE_EN.
package disp_pkg;

   typedef enum logic {IDLE, HOLD} state_t;

   localparam int DIGITS = 4;
   localparam int BCD_W = DIGITS * 4;
   localparam logic [BCD_W-1:0] BLANK_WORD = 16'hFFFF;

   // Index increment that wraps at n, used for round-robin pointers.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 == n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after start,
// optionally skipping one excluded index.
module rr_pick #(
   parameter int N = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   input  logic             excl_en,
   input  logic [IDX_W-1:0] excl_idx,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   int pos;

   // Scan from farthest to nearest so the nearest eligible request is written last and wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      pos = 0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = (int'(start) + k) % N;
         if (req[pos] && !(excl_en && pos == int'(excl_idx))) begin
            found = 1'b1;
            index = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin sharing of the 4-digit BCD display path with a minimum dwell per owner.
// Build option: define DISP_BLANK_IDLE_EN to blank the display when the arbiter goes idle.
module disp_share_arbiter
   import disp_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int DWELL_CYCLES = 1024,
   localparam int CNT_W = $clog2(DWELL_CYCLES + 1),
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [BCD_W*N_REQ-1:0] bcd_in,
   output logic [N_REQ-1:0]       grant,
   output logic [IDX_W-1:0]       owner,
   output logic [BCD_W-1:0]       bcd_out,
   output logic                   busy
);

   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [CNT_W-1:0]  dwell_cnt;

   logic [IDX_W-1:0]  owner_next;
   logic [IDX_W-1:0]  pick_start;
   logic              pick_excl;
   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W-1:0]  pick_next;
   logic [N_REQ-1:0]  pick_onehot;
   logic [BCD_W-1:0]  pick_bcd;
   logic [BCD_W-1:0]  owner_bcd;

   // In HOLD the search starts just past the owner and skips it; in IDLE it starts at rr_ptr.
   always_comb begin
      owner_next = IDX_W'(wrap_inc(int'(owner), N_REQ));
      pick_next = IDX_W'(wrap_inc(int'(pick_idx), N_REQ));
      pick_start = (state == HOLD) ? owner_next : rr_ptr;
      pick_excl = (state == HOLD);
      pick_onehot = '0;
      pick_onehot[pick_idx] = 1'b1;
      pick_bcd = bcd_in[int'(pick_idx)*BCD_W +: BCD_W];
      owner_bcd = bcd_in[int'(owner)*BCD_W +: BCD_W];
   end

   rr_pick #(
      .N(N_REQ),
      .IDX_W(IDX_W)
   ) u_pick (
      .req(req),
      .start(pick_start),
      .excl_en(pick_excl),
      .excl_idx(owner),
      .found(pick_found),
      .index(pick_idx)
   );

   // Arbitration FSM; once dwell has expired, a waiting requester beats the current owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         owner <= '0;
         bcd_out <= '0;
         busy <= 1'b0;
         rr_ptr <= '0;
         dwell_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state <= HOLD;
                  grant <= pick_onehot;
                  owner <= pick_idx;
                  bcd_out <= pick_bcd;
                  dwell_cnt <= DWELL_LOAD;
                  busy <= 1'b1;
               end
            end
            HOLD: begin
               if (dwell_cnt != '0) begin
                  dwell_cnt <= dwell_cnt - 1'b1;
                  if (req[owner]) bcd_out <= owner_bcd;
               end else if (pick_found) begin
                  grant <= pick_onehot;
                  owner <= pick_idx;
                  bcd_out <= pick_bcd;
                  dwell_cnt <= DWELL_LOAD;
                  rr_ptr <= pick_next;
               end else if (req[owner]) begin
                  bcd_out <= owner_bcd;
               end else begin
                  state <= IDLE;
                  grant <= '0;
                  busy <= 1'b0;
                  rr_ptr <= owner_next;
`ifdef DISP_BLANK_IDLE_EN
                  bcd_out <= BLANK_WORD;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed self-checking bench for disp_share_arbiter with N_REQ=4, DWELL_CYCLES=4.
// Expected idle display value depends on DISP_BLANK_IDLE_EN.
module tb_disp_share_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] bcd_in;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic [15:0] bcd_out;
   logic        busy;

   int checks = 0;
   int failures = 0;

   disp_share_arbiter #(
      .N_REQ(4),
      .DWELL_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .bcd_in(bcd_in),
      .grant(grant),
      .owner(owner),
      .bcd_out(bcd_out),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

`ifdef DISP_BLANK_IDLE_EN
   localparam logic [15:0] IDLE_WORD = 16'hFFFF;
`else
   localparam logic [15:0] IDLE_WORD = 16'h4444;
`endif

   initial begin
      logic [3:0]  exp_grant;
      logic [15:0] exp_word;
      int          o;

      rst = 1'b1;
      req = 4'b1111;
      bcd_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

      // Reset held for two cycles with every request asserted.
      step();
      step();
      check_output("reset_grant", 32'(grant), 32'h0);
      check_output("reset_bcd", 32'(bcd_out), 32'h0);
      check_output("reset_busy", 32'(busy), 32'h0);
      check_output("reset_owner", 32'(owner), 32'h0);

      // Release: requester 0 wins on the first edge, then full rotation 0,1,2,3,0.
      rst = 1'b0;
      step();
      for (int cyc = 0; cyc < 20; cyc++) begin
         o = (cyc / 4) % 4;
         exp_grant = 4'b0001 << o;
         exp_word = 16'(16'h1111 * (o + 1));
         check_output($sformatf("rot_grant_c%0d", cyc), 32'(grant), 32'(exp_grant));
         check_output($sformatf("rot_owner_c%0d", cyc), 32'(owner), 32'(o));
         check_output($sformatf("rot_bcd_c%0d", cyc), 32'(bcd_out), 32'(exp_word));
         check_output($sformatf("rot_busy_c%0d", cyc), 32'(busy), 32'h1);
         step();
      end

      // Owner 1 just granted; it tracks its input once, then drops while requester 3 waits.
      check_output("drop_grant0", 32'(grant), 32'h2);
      req = 4'b0010;
      bcd_in[16 +: 16] = 16'h2468;
      step();
      check_output("drop_track", 32'(bcd_out), 32'h2468);
      req = 4'b1000;
      bcd_in[16 +: 16] = 16'h9999;
      step();
      check_output("drop_grant2", 32'(grant), 32'h2);
      check_output("drop_frozen2", 32'(bcd_out), 32'h2468);
      step();
      check_output("drop_grant3", 32'(grant), 32'h2);
      check_output("drop_frozen3", 32'(bcd_out), 32'h2468);
      step();
      check_output("drop_switch_grant", 32'(grant), 32'h8);
      check_output("drop_switch_owner", 32'(owner), 32'h3);
      check_output("drop_switch_bcd", 32'(bcd_out), 32'h4444);

      // Sole owner 3 releases; dwell still runs to completion before going idle.
      req = 4'b0000;
      step();
      step();
      step();
      check_output("idle_pre_grant", 32'(grant), 32'h8);
      check_output("idle_pre_busy", 32'(busy), 32'h1);
      step();
      check_output("idle_grant", 32'(grant), 32'h0);
      check_output("idle_busy", 32'(busy), 32'h0);
      check_output("idle_owner", 32'(owner), 32'h3);
      check_output("idle_bcd", 32'(bcd_out), 32'(IDLE_WORD));
      step();
      check_output("idle_bcd_hold", 32'(bcd_out), 32'(IDLE_WORD));

      // Single requester 2 keeps the display past its dwell and tracks a new value.
      req = 4'b0100;
      bcd_in[32 +: 16] = 16'h1234;
      step();
      check_output("single_grant", 32'(grant), 32'h4);
      check_output("single_bcd", 32'(bcd_out), 32'h1234);
      for (int c = 0; c < 9; c++) begin
         step();
         check_output($sformatf("single_hold_c%0d", c), 32'(grant), 32'h4);
      end
      bcd_in[32 +: 16] = 16'h5678;
      check_output("single_bcd_before", 32'(bcd_out), 32'h1234);
      step();
      check_output("single_bcd_after", 32'(bcd_out), 32'h5678);

      // Go idle (rr_ptr becomes 3), grant requester 3, then reset on dwell cycle 2.
      req = 4'b0000;
      step();
      check_output("pre_rst_idle", 32'(grant), 32'h0);
      req = 4'b1000;
      step();
      check_output("pre_rst_grant", 32'(grant), 32'h8);
      step();
      rst = 1'b1;
      req = 4'b1111;
      step();
      check_output("midrst_grant", 32'(grant), 32'h0);
      check_output("midrst_owner", 32'(owner), 32'h0);
      check_output("midrst_bcd", 32'(bcd_out), 32'h0);
      check_output("midrst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      step();
      check_output("restart_grant", 32'(grant), 32'h1);
      check_output("restart_bcd", 32'(bcd_out), 32'h1111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
